// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the MIPS register file.
package regfile_pkg;

  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_DATA_W-1:0] reg_word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  function automatic logic isZeroReg(input reg_addr_t addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/mips_register_file_if.sv
// Register-file access bus: two read ports and one write port.
interface mips_register_file_if #(
  parameter int unsigned DATA_W = regfile_pkg::REG_DATA_W
);

  regfile_pkg::reg_addr_t RA;
  regfile_pkg::reg_addr_t RB;
  regfile_pkg::reg_addr_t RW;
  logic                   RegWr;
  logic [DATA_W-1:0]      BusW;
  logic [DATA_W-1:0]      BusA;
  logic [DATA_W-1:0]      BusB;

  modport master (
    output RA, RB, RW, RegWr, BusW,
    input  BusA, BusB
  );

  modport slave (
    input  RA, RB, RW, RegWr, BusW,
    output BusA, BusB
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: register-0 masking plus optional write-through
// forwarding when REGFILE_BYPASS_EN is defined.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  reg_addr_t         addr,
  input  logic [DATA_W-1:0] regs [1:NUM_REGS-1],
  input  logic              rst,
  input  logic              wrEn,
  input  reg_addr_t         wrAddr,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = '0;
    if (!isZeroReg(addr)) begin
      data = regs[addr];
    end
`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write so a same-cycle reader sees the new value.
    if (wrEn && !rst && !isZeroReg(wrAddr) && (wrAddr == addr)) begin
      data = wrData;
    end
`endif
  end

`ifndef REGFILE_BYPASS_EN
  logic unusedBypass;
  assign unusedBypass = ^{rst, wrEn, wrAddr, wrData};
`endif

endmodule

// File: rtl/mips_register_file.sv
// 32 x DATA_W register file, r0 hardwired to zero, flat debug export of every
// register. Define REGFILE_BYPASS_EN for write-through forwarding on reads.
module mips_register_file
  import regfile_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                Clk,
  input  logic                Rst,
  mips_register_file_if.slave bus,
  output logic [DATA_W-1:0]   regOut0,
  output logic [DATA_W-1:0]   regOut1,
  output logic [DATA_W-1:0]   regOut2,
  output logic [DATA_W-1:0]   regOut3,
  output logic [DATA_W-1:0]   regOut4,
  output logic [DATA_W-1:0]   regOut5,
  output logic [DATA_W-1:0]   regOut6,
  output logic [DATA_W-1:0]   regOut7,
  output logic [DATA_W-1:0]   regOut8,
  output logic [DATA_W-1:0]   regOut9,
  output logic [DATA_W-1:0]   regOut10,
  output logic [DATA_W-1:0]   regOut11,
  output logic [DATA_W-1:0]   regOut12,
  output logic [DATA_W-1:0]   regOut13,
  output logic [DATA_W-1:0]   regOut14,
  output logic [DATA_W-1:0]   regOut15,
  output logic [DATA_W-1:0]   regOut16,
  output logic [DATA_W-1:0]   regOut17,
  output logic [DATA_W-1:0]   regOut18,
  output logic [DATA_W-1:0]   regOut19,
  output logic [DATA_W-1:0]   regOut20,
  output logic [DATA_W-1:0]   regOut21,
  output logic [DATA_W-1:0]   regOut22,
  output logic [DATA_W-1:0]   regOut23,
  output logic [DATA_W-1:0]   regOut24,
  output logic [DATA_W-1:0]   regOut25,
  output logic [DATA_W-1:0]   regOut26,
  output logic [DATA_W-1:0]   regOut27,
  output logic [DATA_W-1:0]   regOut28,
  output logic [DATA_W-1:0]   regOut29,
  output logic [DATA_W-1:0]   regOut30,
  output logic [DATA_W-1:0]   regOut31
);

  // r0 has no storage; readers substitute zero for it.
  logic [DATA_W-1:0] regs [1:NUM_REGS-1];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else if (bus.RegWr && !isZeroReg(bus.RW)) begin
      regs[bus.RW] <= bus.BusW;
    end
  end

  regfile_read_port #(
    .DATA_W (DATA_W)
  ) u_read_a (
    .addr   (bus.RA),
    .regs   (regs),
    .rst    (Rst),
    .wrEn   (bus.RegWr),
    .wrAddr (bus.RW),
    .wrData (bus.BusW),
    .data   (bus.BusA)
  );

  regfile_read_port #(
    .DATA_W (DATA_W)
  ) u_read_b (
    .addr   (bus.RB),
    .regs   (regs),
    .rst    (Rst),
    .wrEn   (bus.RegWr),
    .wrAddr (bus.RW),
    .wrData (bus.BusW),
    .data   (bus.BusB)
  );

  assign regOut0  = '0;
  assign regOut1  = regs[1];
  assign regOut2  = regs[2];
  assign regOut3  = regs[3];
  assign regOut4  = regs[4];
  assign regOut5  = regs[5];
  assign regOut6  = regs[6];
  assign regOut7  = regs[7];
  assign regOut8  = regs[8];
  assign regOut9  = regs[9];
  assign regOut10 = regs[10];
  assign regOut11 = regs[11];
  assign regOut12 = regs[12];
  assign regOut13 = regs[13];
  assign regOut14 = regs[14];
  assign regOut15 = regs[15];
  assign regOut16 = regs[16];
  assign regOut17 = regs[17];
  assign regOut18 = regs[18];
  assign regOut19 = regs[19];
  assign regOut20 = regs[20];
  assign regOut21 = regs[21];
  assign regOut22 = regs[22];
  assign regOut23 = regs[23];
  assign regOut24 = regs[24];
  assign regOut25 = regs[25];
  assign regOut26 = regs[26];
  assign regOut27 = regs[27];
  assign regOut28 = regs[28];
  assign regOut29 = regs[29];
  assign regOut30 = regs[30];
  assign regOut31 = regs[31];

endmodule

// File: tb/tb_mips_register_file.sv
// Directed bench for mips_register_file with an array-based reference model;
// expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_mips_register_file;
  import regfile_pkg::*;

  logic        Clk;
  logic        Rst;
  logic [31:0] regOut [32];

  mips_register_file_if #(.DATA_W(32)) bus ();

  mips_register_file #(
    .DATA_W    (32),
    .RESET_VAL (32'h0)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .bus      (bus),
    .regOut0  (regOut[0]),
    .regOut1  (regOut[1]),
    .regOut2  (regOut[2]),
    .regOut3  (regOut[3]),
    .regOut4  (regOut[4]),
    .regOut5  (regOut[5]),
    .regOut6  (regOut[6]),
    .regOut7  (regOut[7]),
    .regOut8  (regOut[8]),
    .regOut9  (regOut[9]),
    .regOut10 (regOut[10]),
    .regOut11 (regOut[11]),
    .regOut12 (regOut[12]),
    .regOut13 (regOut[13]),
    .regOut14 (regOut[14]),
    .regOut15 (regOut[15]),
    .regOut16 (regOut[16]),
    .regOut17 (regOut[17]),
    .regOut18 (regOut[18]),
    .regOut19 (regOut[19]),
    .regOut20 (regOut[20]),
    .regOut21 (regOut[21]),
    .regOut22 (regOut[22]),
    .regOut23 (regOut[23]),
    .regOut24 (regOut[24]),
    .regOut25 (regOut[25]),
    .regOut26 (regOut[26]),
    .regOut27 (regOut[27]),
    .regOut28 (regOut[28]),
    .regOut29 (regOut[29]),
    .regOut30 (regOut[30]),
    .regOut31 (regOut[31])
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  reg_word_t model [32];
  logic      checkEn = 1'b0;
  int        checks = 0;
  int        failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic reg_word_t expRead(input reg_addr_t a);
    if (a == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.RegWr && !Rst && bus.RW == a) return bus.BusW;
`endif
    return model[a];
  endfunction

  task automatic compareModel();
    check("model_BusA", bus.BusA, expRead(bus.RA));
    check("model_BusB", bus.BusB, expRead(bus.RB));
    for (int i = 0; i < 32; i++) begin
      check($sformatf("model_regOut%0d", i), regOut[i], (i == 0) ? 32'h0 : model[i]);
    end
  endtask

  task automatic drive(input logic rst, input logic wr, input logic [4:0] rw,
                       input logic [31:0] w, input logic [4:0] ra, input logic [4:0] rb);
    Rst       = rst;
    bus.RegWr = wr;
    bus.RW    = rw;
    bus.BusW  = w;
    bus.RA    = ra;
    bus.RB    = rb;
  endtask

  // Compare before the edge, then advance the model by one rising edge.
  task automatic cycle();
    @(negedge Clk);
    if (checkEn) compareModel();
    @(posedge Clk);
    if (Rst) begin
      for (int i = 1; i < 32; i++) model[i] = '0;
    end else if (bus.RegWr && bus.RW != 5'd0) begin
      model[bus.RW] = bus.BusW;
    end
    #1;
  endtask

  initial begin
    logic [31:0] v;
    model[0] = '0;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1;
    check("pre_reset_regOut0", regOut[0], 32'h0);
    check("pre_reset_BusA_r0", bus.BusA, 32'h0);

    // 1: reset
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    cycle();
    checkEn = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd17);
    #1;
    check("reset_BusA", bus.BusA, 32'h0);
    check("reset_BusB", bus.BusB, 32'h0);
    for (int i = 0; i < 32; i++) check($sformatf("reset_regOut%0d", i), regOut[i], 32'h0);
    cycle();

    // 2: basic write
    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2);
    cycle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    #1;
    check("wr5_BusA", bus.BusA, 32'hDEADBEEF);
    check("wr5_BusB", bus.BusB, 32'hDEADBEEF);
    check("wr5_regOut5", regOut[5], 32'hDEADBEEF);
    cycle();

    // 3: writes to r0 are dropped, including on the bypass path
    drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    #1;
    check("r0_wr_BusA_pre", bus.BusA, 32'h0);
    cycle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
    #1;
    check("r0_regOut0", regOut[0], 32'h0);
    check("r0_BusA", bus.BusA, 32'h0);
    cycle();

    // 4: RegWr=0 ignored; reset needs an edge; reset beats write
    drive(1'b0, 1'b0, 5'd7, 32'h1234, 5'd7, 5'd0);
    cycle();
    check("nowr_regOut7", regOut[7], 32'h0);
    drive(1'b1, 1'b1, 5'd7, 32'h55, 5'd5, 5'd7);
    #1;
    check("rst_noedge_regOut5", regOut[5], 32'hDEADBEEF);
    check("rst_nobypass_BusB", bus.BusB, 32'h0);
    cycle();
    check("rstwins_regOut7", regOut[7], 32'h0);
    check("rstwins_regOut5", regOut[5], 32'h0);

    // 5: two writes, then same-cycle read of the write register
    drive(1'b0, 1'b1, 5'd3, 32'h11, 5'd0, 5'd0);
    cycle();
    drive(1'b0, 1'b1, 5'd4, 32'h22, 5'd0, 5'd0);
    cycle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
    #1;
    check("rd3_BusA", bus.BusA, 32'h11);
    check("rd4_BusB", bus.BusB, 32'h22);
    cycle();
    drive(1'b0, 1'b1, 5'd3, 32'h33, 5'd3, 5'd3);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cycle_BusA", bus.BusA, 32'h33);
    check("same_cycle_BusB", bus.BusB, 32'h33);
`else
    check("same_cycle_BusA", bus.BusA, 32'h11);
    check("same_cycle_BusB", bus.BusB, 32'h11);
`endif
    check("same_cycle_regOut3", regOut[3], 32'h11);
    cycle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
    #1;
    check("after_edge_BusA", bus.BusA, 32'h33);
    check("after_edge_BusB", bus.BusB, 32'h22);
    cycle();
    // Reset in the same cycle must suppress forwarding
    drive(1'b1, 1'b1, 5'd4, 32'h44, 5'd4, 5'd0);
    #1;
    check("rst_bypass_BusA", bus.BusA, 32'h22);
    cycle();
    check("rst_bypass_regOut4", regOut[4], 32'h0);

    // 6: sweep every register, then read all pairs
    for (int n = 1; n < 32; n++) begin
      v = 32'(n) * 32'h01010101;
      drive(1'b0, 1'b1, 5'(n), v, 5'(n), 5'd0);
      cycle();
      check($sformatf("sweep_regOut%0d", n), regOut[n], v);
    end
    for (int n = 0; n < 32; n++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(n), 5'(31 - n));
      #1;
      check($sformatf("pair_BusA_r%0d", n), bus.BusA, 32'(n) * 32'h01010101);
      check($sformatf("pair_BusB_r%0d", 31 - n), bus.BusB, 32'(31 - n) * 32'h01010101);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
